// File: rtl/subword_pkg.sv
// -----------------------------------------------------------------------------
// subword_pkg
//
// Shared definitions for the subword packing stage: word geometry, the lane
// index type and the FIFO entry layout (per-lane written mask + word data).
// -----------------------------------------------------------------------------
package subword_pkg;

    localparam int LANES  = 4;              // nibble lanes per word
    localparam int NIB_W  = 4;              // bits per lane
    localparam int WORD_W = LANES * NIB_W;  // 16-bit packed word

    // Lane index: lane k covers word bits [4k+3:4k].
    typedef logic [1:0] lane_t;

    localparam lane_t LAST_LANE = lane_t'(LANES - 1);

    // One queued word: which lanes were written, and the merged data.
    typedef struct packed {
        logic [LANES-1:0]  mask;
        logic [WORD_W-1:0] data;
    } entry_t;

endpackage : subword_pkg

// File: rtl/subword_fifo.sv
// -----------------------------------------------------------------------------
// subword_fifo
//
// Circular-buffer FIFO of entry_t words. Pointers wrap modulo DEPTH (DEPTH is
// a power of two, so the natural pointer rollover does the wrap). Occupancy is
// tracked by an explicit level counter so full and empty are unambiguous.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   i_push       write i_push_data at the tail (ignored while full)
//   i_push_data  entry to enqueue
//   i_pop        drop the head entry (ignored while empty)
//   o_full       level == DEPTH
//   o_empty      level == 0
//   o_head       head entry; all zeros while empty
//   o_level      current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module subword_fifo
    import subword_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  entry_t                       i_push_data,
    input  logic                         i_pop,
    output logic                         o_full,
    output logic                         o_empty,
    output entry_t                       o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    entry_t           r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_level == LVL_W'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop  && !o_empty;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            // Simultaneous push and pop leaves the level unchanged.
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; validity comes from the level
    // counter, and the head is forced to zero while empty.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head = o_empty ? '0 : r_mem[r_rd_ptr];

    a_level_bound : assert property (@(posedge clk) disable iff (!rst_n)
        r_level <= LVL_W'(DEPTH));

endmodule : subword_fifo

// File: rtl/subword_packer.sv
// -----------------------------------------------------------------------------
// subword_packer
//
// Merges nibble/byte fragments into a 16-bit word with a per-lane written
// mask. A fragment tagged in_last closes the word: the merged word (including
// that fragment) is queued in a DEPTH-entry FIFO and the accumulator clears on
// the same edge. A byte fragment aimed at the top lane keeps its low nibble,
// drops the high nibble (no wrap to lane 0) and sets the sticky err flag.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; discards open word and queue
//   in_valid   fragment present
//   in_ready   fragment can be accepted (FIFO not full)
//   in_data    fragment payload; only [3:0] used when in_wide=0
//   in_lane    target nibble lane
//   in_wide    1: byte write to lanes k and k+1
//   in_last    fragment closes the current word
//   out_valid  FIFO head valid
//   out_ready  consumer takes the head
//   out_data   head word (0 while empty)
//   out_mask   head per-lane written mask (0 while empty)
//   level      FIFO occupancy
//   err        sticky: a byte write overflowed past the top lane
// -----------------------------------------------------------------------------
module subword_packer
    import subword_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [7:0]                   in_data,
    input  lane_t                        in_lane,
    input  logic                         in_wide,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WORD_W-1:0]            out_data,
    output logic [LANES-1:0]             out_mask,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         err
);

    // Next value of the accumulator after writing one fragment. Each target
    // lane is examined on its own: it takes the low nibble when it is the
    // addressed lane, or the high nibble of a byte addressed to the lane
    // below it. Lane 0 has no lane below, which is what prevents wrap-around.
    function automatic entry_t next_acc(
        input entry_t      cur,
        input logic [7:0]  data,
        input lane_t       lane,
        input logic        wide
    );
        entry_t nxt;
        nxt = cur;
        for (int j = 0; j < LANES; j++) begin
            if (lane == lane_t'(j)) begin
                nxt.data[j*NIB_W +: NIB_W] = data[NIB_W-1:0];
                nxt.mask[j]                = 1'b1;
            end else if (wide && (j > 0) && (lane == lane_t'(j - 1))) begin
                nxt.data[j*NIB_W +: NIB_W] = data[2*NIB_W-1:NIB_W];
                nxt.mask[j]                = 1'b1;
            end
        end
        return nxt;
    endfunction

    entry_t r_acc;
    logic   r_err;

    entry_t w_merged;
    entry_t w_head;
    logic   w_accept;
    logic   w_push;
    logic   w_pop;
    logic   w_full;
    logic   w_empty;

    // NOTE: combinational logic assigns every output on every path (here via
    // continuous assigns and a function that starts from a full copy), so no
    // latch can be inferred.
    assign w_merged  = next_acc(r_acc, in_data, in_lane, in_wide);

    // in_ready looks only at the current level, never at out_ready, so a
    // full FIFO refuses input even in a cycle where it is being drained.
    assign in_ready  = !w_full;
    assign out_valid = !w_empty;

    assign w_accept  = in_valid && in_ready;
    assign w_push    = w_accept && in_last;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_accept) begin
            // A closing fragment hands the merged word to the FIFO and starts
            // the next word from an empty accumulator.
            r_acc <= in_last ? '0 : w_merged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept && in_wide && (in_lane == LAST_LANE)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;

    subword_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_merged),
        .i_pop       (w_pop),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head      (w_head),
        .o_level     (level)
    );

    assign out_data = w_head.data;
    assign out_mask = w_head.mask;

endmodule : subword_packer

// File: tb/tb_subword_packer.sv
// -----------------------------------------------------------------------------
// tb_subword_packer
//
// Directed scenarios plus randomized traffic against a nibble-array / queue
// reference model of the packer. Inputs change 1 time unit after the rising
// edge; outputs are sampled there as well.
// -----------------------------------------------------------------------------
module tb_subword_packer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [1:0]  in_lane;
    logic        in_wide;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_mask;
    logic [2:0]  level;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: open word as per-lane values/flags, queue of words.
    logic [19:0] m_q[$];
    logic [3:0]  m_val [4];
    logic        m_wr  [4];
    logic        m_err;

    subword_packer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_lane   (in_lane),
        .in_wide   (in_wide),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mask  (out_mask),
        .level     (level),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] m_word();
        logic [15:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) w = w | (16'(m_val[k]) << (4 * k));
        return w;
    endfunction

    function automatic logic [3:0] m_mask();
        logic [3:0] m;
        m = '0;
        for (int k = 0; k < 4; k++) m[k] = m_wr[k];
        return m;
    endfunction

    task automatic m_clear_word();
        for (int k = 0; k < 4; k++) begin
            m_val[k] = '0;
            m_wr[k]  = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_clear_word();
        m_err = 1'b0;
    endtask

    // Clock one edge with the currently driven inputs and apply the same
    // transaction to the model (decisions taken from pre-edge model state).
    task automatic advance();
        logic acc;
        logic pop;
        acc = in_valid && (m_q.size() < DEPTH);
        pop = out_ready && (m_q.size() > 0);
        @(posedge clk);
        if (pop) void'(m_q.pop_front());
        if (acc) begin
            m_val[in_lane] = in_data[3:0];
            m_wr[in_lane]  = 1'b1;
            if (in_wide) begin
                if (in_lane < 2'd3) begin
                    m_val[in_lane + 1] = in_data[7:4];
                    m_wr[in_lane + 1]  = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (in_last) begin
                m_q.push_back({m_mask(), m_word()});
                m_clear_word();
            end
        end
        #1;
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic [1:0] l,
                        input logic w, input logic la, input logic ordy);
        in_valid  = v;
        in_data   = d;
        in_lane   = l;
        in_wide   = w;
        in_last   = la;
        out_ready = ordy;
        advance();
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 0; in_data = 0; in_lane = 0;
        in_wide = 0; in_last = 0; out_ready = 0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_tests++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", level); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
        n_tests++; if (out_data !== 16'h0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
        n_tests++; if (out_mask !== 4'h0) begin n_fail++; $display("FAIL reset_out_mask got=%h exp=0", out_mask); end
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_narrow();
        step(1, 8'h01, 2'd0, 0, 0, 0);
        step(1, 8'h02, 2'd1, 0, 0, 0);
        step(1, 8'h03, 2'd2, 0, 0, 0);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL narrow_open_word_valid got=%b exp=0", out_valid); end
        step(1, 8'h04, 2'd3, 0, 1, 0);
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL narrow_latency got=%b exp=1", out_valid); end
        n_tests++; if (out_data !== 16'h4321) begin n_fail++; $display("FAIL narrow_data got=%h exp=4321", out_data); end
        n_tests++; if (out_mask !== 4'hF) begin n_fail++; $display("FAIL narrow_mask got=%h exp=f", out_mask); end
        n_tests++; if (level !== 3'd1) begin n_fail++; $display("FAIL narrow_level got=%0d exp=1", level); end
        step(0, 8'h00, 2'd0, 0, 0, 1);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL narrow_pop_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_wide();
        step(1, 8'hAB, 2'd1, 1, 1, 0);
        n_tests++; if (out_data !== 16'h0AB0) begin n_fail++; $display("FAIL wide_data got=%h exp=0ab0", out_data); end
        n_tests++; if (out_mask !== 4'h6) begin n_fail++; $display("FAIL wide_mask got=%h exp=6", out_mask); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL wide_err got=%b exp=0", err); end
        step(0, 8'h00, 2'd0, 0, 0, 1);
    endtask

    task automatic test_wide_overflow();
        step(1, 8'hCD, 2'd3, 1, 1, 0);
        n_tests++; if (out_data !== 16'hD000) begin n_fail++; $display("FAIL ovf_data got=%h exp=d000", out_data); end
        n_tests++; if (out_mask !== 4'h8) begin n_fail++; $display("FAIL ovf_mask got=%h exp=8", out_mask); end
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL ovf_err got=%b exp=1", err); end
        step(0, 8'h00, 2'd0, 0, 0, 1);
        // out_ready=1 on an empty FIFO is ignored; the new word must survive.
        step(1, 8'h05, 2'd0, 0, 1, 1);
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL ovf_err_sticky got=%b exp=1", err); end
        n_tests++; if (out_data !== 16'h0005 || level !== 3'd1) begin n_fail++; $display("FAIL ovf_next_word got=%h/%0d exp=0005/1", out_data, level); end
        step(0, 8'h00, 2'd0, 0, 0, 1);
    endtask

    task automatic test_full();
        logic [15:0] exp_d;
        logic [3:0]  exp_m;
        for (int i = 0; i < 4; i++) step(1, 8'(i + 1), 2'(i), 0, 1, 0);
        n_tests++; if (level !== 3'd4) begin n_fail++; $display("FAIL full_level got=%0d exp=4", level); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
        step(1, 8'h05, 2'd0, 0, 1, 0);
        n_tests++; if (level !== 3'd4 || out_data !== 16'h0001) begin n_fail++; $display("FAIL full_reject got=%0d/%h exp=4/0001", level, out_data); end
        step(0, 8'h00, 2'd0, 0, 0, 1);
        n_tests++; if (in_ready !== 1'b1 || level !== 3'd3) begin n_fail++; $display("FAIL full_pop_ready got=%b/%0d exp=1/3", in_ready, level); end
        step(1, 8'h05, 2'd0, 0, 1, 0);
        n_tests++; if (level !== 3'd4) begin n_fail++; $display("FAIL full_refill got=%0d exp=4", level); end
        for (int i = 1; i <= 4; i++) begin
            exp_d = 16'(i + 1) << (4 * (i % 4));
            exp_m = 4'(1 << (i % 4));
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== exp_d || out_mask !== exp_m) begin
                n_fail++;
                $display("FAIL full_drain_%0d got=%b/%h/%h exp=1/%h/%h", i, out_valid, out_data, out_mask, exp_d, exp_m);
            end
            step(0, 8'h00, 2'd0, 0, 0, 1);
        end
        n_tests++; if (out_valid !== 1'b0 || level !== 3'd0) begin n_fail++; $display("FAIL full_drained got=%b/%0d exp=0/0", out_valid, level); end
    endtask

    task automatic test_full_same_cycle();
        for (int i = 0; i < 4; i++)
            step(1, 8'($urandom), 2'($urandom), 1'($urandom), 1, 0);
        n_tests++; if (level !== 3'd4) begin n_fail++; $display("FAIL same_full_level got=%0d exp=4", level); end
        in_valid = 1; in_data = 8'h9E; in_lane = 2'd2; in_wide = 0; in_last = 1; out_ready = 1;
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL same_in_ready got=%b exp=0", in_ready); end
        advance();
        n_tests++; if (level !== 3'd3) begin n_fail++; $display("FAIL same_pop_only got=%0d exp=3", level); end
        advance();
        n_tests++; if (level !== 3'd3) begin n_fail++; $display("FAIL same_push_pop got=%0d exp=3", level); end
        in_valid = 0; out_ready = 0;
        for (int i = 0; i < DEPTH + 1 && m_q.size() > 0; i++) begin
            n_tests++;
            if (out_data !== m_q[0][15:0] || out_mask !== m_q[0][19:16]) begin
                n_fail++;
                $display("FAIL same_drain_%0d got=%h/%h exp=%h/%h", i, out_data, out_mask, m_q[0][15:0], m_q[0][19:16]);
            end
            step(0, 8'h00, 2'd0, 0, 0, 1);
        end
        n_tests++; if (level !== 3'd0) begin n_fail++; $display("FAIL same_drained got=%0d exp=0", level); end
    endtask

    task automatic test_reset_mid();
        step(1, 8'h0A, 2'd0, 0, 1, 0);
        step(1, 8'h0B, 2'd1, 0, 1, 0);
        step(1, 8'h09, 2'd1, 0, 0, 0);
        step(1, 8'hCD, 2'd3, 1, 0, 0);
        n_tests++; if (level !== 3'd2 || err !== 1'b1) begin n_fail++; $display("FAIL mid_pre got=%0d/%b exp=2/1", level, err); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
        n_tests++; if (level !== 3'd0) begin n_fail++; $display("FAIL mid_level got=%0d exp=0", level); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL mid_err got=%b exp=0", err); end
        n_tests++; if (in_ready !== 1'b1 || out_data !== 16'h0) begin n_fail++; $display("FAIL mid_outputs got=%b/%h exp=1/0000", in_ready, out_data); end
        model_reset();
        #2 rst_n = 1'b1;
        step(1, 8'h07, 2'd0, 0, 1, 0);
        n_tests++; if (out_data !== 16'h0007 || out_mask !== 4'h1) begin n_fail++; $display("FAIL mid_fresh_word got=%h/%h exp=0007/1", out_data, out_mask); end
        step(0, 8'h00, 2'd0, 0, 0, 1);
    endtask

    task automatic test_random();
        logic [15:0] exp_d;
        logic [3:0]  exp_m;
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            in_lane   = 2'($urandom);
            in_wide   = 1'($urandom);
            in_last   = ($urandom_range(0, 2) == 0);
            out_ready = ((i / 50) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            #1;
            exp_d = (m_q.size() > 0) ? m_q[0][15:0]  : 16'h0;
            exp_m = (m_q.size() > 0) ? m_q[0][19:16] : 4'h0;
            n_tests++; if (in_ready !== (m_q.size() < DEPTH)) begin n_fail++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", i, in_ready, m_q.size() < DEPTH); end
            n_tests++; if (out_valid !== (m_q.size() > 0)) begin n_fail++; $display("FAIL rand_out_valid cyc=%0d got=%b exp=%b", i, out_valid, m_q.size() > 0); end
            n_tests++; if (level !== 3'(m_q.size())) begin n_fail++; $display("FAIL rand_level cyc=%0d got=%0d exp=%0d", i, level, m_q.size()); end
            n_tests++; if (out_data !== exp_d || out_mask !== exp_m) begin n_fail++; $display("FAIL rand_head cyc=%0d got=%h/%h exp=%h/%h", i, out_data, out_mask, exp_d, exp_m); end
            n_tests++; if (err !== m_err) begin n_fail++; $display("FAIL rand_err cyc=%0d got=%b exp=%b", i, err, m_err); end
            advance();
        end
        in_valid = 0; out_ready = 0;
    endtask

    initial begin
        test_reset();
        test_narrow();
        test_wide();
        test_wide_overflow();
        test_full();
        test_full_same_cycle();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_subword_packer

// File: doc/subword_packer.md
# subword_packer

Downstream packing stage for the subword register examples. It accepts nibble- and byte-sized fragments tagged with a lane index, merges them into a 16-bit word with a per-nibble write mask, and queues each completed word in a small FIFO. The subword-DFF stages produce this kind of partial-width traffic, and this block turns it into whole words for downstream consumers. It exercises partial-select register writes, a ready/valid handshake and a circular buffer in one block.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  fragment present.
- in_ready  output  1  block can accept a fragment.
- in_data  input  8  fragment payload; [3:0] only when in_wide=0.
- in_lane  input  2  target nibble lane (lane k = word bits 4k+3:4k).
- in_wide  input  1  1: byte write to lanes k and k+1.
- in_last  input  1  fragment closes the current word.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer takes head.
- out_data  output  16  head word.
- out_mask  output  4  head per-lane written mask.
- level  output  $clog2(DEPTH+1)  FIFO occupancy.
- err  output  1  sticky overflow-lane flag.

## Operation
- Accept when in_valid && in_ready. in_ready = (level != DEPTH) and does not depend on out_ready in the same cycle.
- Narrow beat: acc[4k+3:4k] <= in_data[3:0]; mask[k] <= 1.
- Wide beat, k<3: lane k <= in_data[3:0], lane k+1 <= in_data[7:4]; both mask bits set.
- Wide beat, k=3: lane 3 <= in_data[3:0]. in_data[7:4] is dropped with no wrap to lane 0. err <= 1.
- Rewriting a lane overwrites its data; its mask bit stays 1.
- Beat with in_last: push {merged mask, merged acc}. The merge includes this beat's writes. acc and mask clear to 0 on the same edge.
- Lanes never written in a word read as 0 in out_data.
- in_last on an otherwise empty word is legal and pushes the single-beat word.
- Pop when out_valid && out_ready. out_valid = (level != 0). out_data and out_mask come from the head entry.
- Push and pop in the same cycle: level unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.

## Timing
- Reset values: acc=0, mask=0, level=0, rd/wr pointers=0, err=0, out_valid=0, in_ready=1, out_data and out_mask drive 0 while level=0.
- Latency: in_last beat accepted at edge N with FIFO empty means out_valid=1 in the cycle after edge N, with data stable until popped.
- Full: level=DEPTH means in_ready=0, even if out_ready=1 that cycle. in_ready returns to 1 in the cycle after the pop edge.
- Empty: out_valid=0; out_ready is ignored.
- Reset asserted mid-word or with entries queued discards all of them immediately, asynchronously. The first post-reset beat starts a fresh word.
- err is cleared only by rst_n.

## Structure
- Package subword_pkg holds:
  - LANES=4, NIB_W=4, WORD_W=16
  - lane_t (2-bit)
  - entry_t struct {mask[3:0], data[15:0]}
- Sub-module subword_fifo, parameterised by DEPTH, stores entry_t. It provides push/pop, full/empty and level.
- Lane merge logic lives in subword_packer as a combinational next-acc function.

## Test plan
- Narrow beats 0x1@lane0, 0x2@lane1, 0x3@lane2, then 0x4@lane3 with last -> one entry data=0x4321, mask=0xF, out_valid the cycle after the last edge.
- Wide 0xAB@lane1 with last -> data=0x0AB0, mask=0x6.
- Wide 0xCD@lane3 with last -> data=0xD000, mask=0x8, err=1, and err stays 1 after further words.
- Hold out_ready=0 and push 5 single-beat words -> level=4, in_ready=0, 5th beat not accepted. Pop one -> in_ready=1 the next cycle, then 5th accepted. Drain order matches push order across pointer wrap.
- Full FIFO with out_ready=1 and in_valid=1 on the same cycle -> pop only, level 4->3. Next cycle: push+pop, level stays 3.
- Assert rst_n low after 2 beats of an open word and 2 queued entries -> out_valid=0, level=0, err=0 immediately. After release, 0x7@lane0 with last -> data=0x0007, mask=0x1.
